// File: rtl/axis_eth_preamble_strip_if.sv
// Byte-wide AXI stream bundle shared by the preamble stripper's
// raw input and payload output.
interface axis_eth_preamble_strip_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;
  logic       tlast;
  logic       tuser;

  modport master (
    output tdata, tvalid, tlast, tuser,
    input  tready
  );

  modport slave (
    input  tdata, tvalid, tlast, tuser,
    output tready
  );
endinterface

// File: rtl/axis_eth_preamble_strip.sv
// Validates and removes Ethernet preamble/SFD from a byte stream,
// flags runt frames and discards frames with malformed preambles.
module axis_eth_preamble_strip #(
  parameter int MIN_PREAMBLE_LEN = 1,
  parameter int MAX_PREAMBLE_LEN = 7,
  parameter int MIN_FRAME_LENGTH = 64
) (
  input  logic clk,
  input  logic rst,
  axis_eth_preamble_strip_if.slave  s,
  axis_eth_preamble_strip_if.master m,
  output logic busy,
  output logic error_bad_preamble,
  output logic error_runt
);

  localparam logic [4:0]  MIN_PRE = 5'(MIN_PREAMBLE_LEN);
  localparam logic [4:0]  MAX_PRE = 5'(MAX_PREAMBLE_LEN);
  localparam logic [16:0] MIN_LEN = 17'(MIN_FRAME_LENGTH);
  localparam logic [7:0]  PRE_B   = 8'h55;
  localparam logic [7:0]  SFD_B   = 8'hD5;

  typedef enum logic [1:0] {
    IDLE,
    PREAMBLE,
    PAYLOAD,
    DROP
  } state_t;

  state_t      state, state_next;
  logic [3:0]  pre_cnt, pre_cnt_next;
  logic [15:0] len_cnt, len_cnt_next;
  logic        s_ready, s_ready_next;
  logic        bad_next, runt_next;
  logic        accept;
  logic [4:0]  pre_inc;
  logic [16:0] len_inc;

  logic [7:0]  int_data;
  logic        int_valid, int_last, int_user;
  logic        int_ready, int_ready_early;

  logic [7:0]  out_data, tmp_data;
  logic        out_valid, out_last, out_user;
  logic        tmp_valid, tmp_last, tmp_user;
  logic        out_valid_next, tmp_valid_next;
  logic        to_out, to_tmp, tmp_to_out;

  assign accept  = s.tvalid && s_ready;
  assign pre_inc = {1'b0, pre_cnt} + 5'd1;
  assign len_inc = {1'b0, len_cnt} + 17'd1;

  assign s.tready = s_ready;
  assign m.tdata  = out_data;
  assign m.tvalid = out_valid;
  assign m.tlast  = out_last;
  assign m.tuser  = out_user;

  always_comb begin
    state_next   = state;
    pre_cnt_next = pre_cnt;
    len_cnt_next = len_cnt;
    bad_next     = 1'b0;
    runt_next    = 1'b0;
    int_valid    = 1'b0;
    int_data     = s.tdata;
    int_last     = 1'b0;
    int_user     = 1'b0;
    unique case (state)
      IDLE: if (accept) begin
        if (s.tlast) begin
          bad_next = 1'b1;
        end else if (s.tdata == PRE_B && MAX_PRE != 5'd0) begin
          pre_cnt_next = 4'd1;
          state_next   = PREAMBLE;
        end else if (s.tdata == SFD_B && MIN_PRE == 5'd0) begin
          len_cnt_next = 16'd0;
          state_next   = PAYLOAD;
        end else begin
          bad_next   = 1'b1;
          state_next = DROP;
        end
      end
      PREAMBLE: if (accept) begin
        if (s.tlast) begin
          bad_next   = 1'b1;
          state_next = IDLE;
        end else if (s.tdata == PRE_B) begin
          if (pre_inc > MAX_PRE) begin
            bad_next   = 1'b1;
            state_next = DROP;
          end else begin
            pre_cnt_next = pre_inc[3:0];
          end
        end else if (s.tdata == SFD_B &&
                     {1'b0, pre_cnt} >= MIN_PRE) begin
          len_cnt_next = 16'd0;
          state_next   = PAYLOAD;
        end else begin
          bad_next   = 1'b1;
          state_next = DROP;
        end
      end
      PAYLOAD: if (accept) begin
        int_valid    = 1'b1;
        int_last     = s.tlast;
        len_cnt_next = (&len_cnt) ? len_cnt : len_inc[15:0];
        if (s.tlast) begin
          // len_inc counts the last byte itself
          runt_next  = len_inc < MIN_LEN;
          int_user   = s.tuser | runt_next;
          state_next = IDLE;
        end
      end
      DROP: if (accept && s.tlast) begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Ready for the next cycle only if the skid pair cannot overflow
  assign int_ready_early = m.tready ||
    (!tmp_valid && (!out_valid || !int_valid));

  assign s_ready_next = (state_next == PAYLOAD) ?
    int_ready_early : 1'b1;

  always_comb begin
    out_valid_next = out_valid;
    tmp_valid_next = tmp_valid;
    to_out         = 1'b0;
    to_tmp         = 1'b0;
    tmp_to_out     = 1'b0;
    if (int_ready) begin
      if (m.tready || !out_valid) begin
        out_valid_next = int_valid;
        to_out         = 1'b1;
      end else begin
        tmp_valid_next = int_valid;
        to_tmp         = 1'b1;
      end
    end else if (m.tready) begin
      out_valid_next = tmp_valid;
      tmp_valid_next = 1'b0;
      tmp_to_out     = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= IDLE;
      pre_cnt            <= 4'd0;
      len_cnt            <= 16'd0;
      s_ready            <= 1'b0;
      int_ready          <= 1'b0;
      busy               <= 1'b0;
      error_bad_preamble <= 1'b0;
      error_runt         <= 1'b0;
      out_valid          <= 1'b0;
      out_data           <= 8'd0;
      out_last           <= 1'b0;
      out_user           <= 1'b0;
      tmp_valid          <= 1'b0;
      tmp_data           <= 8'd0;
      tmp_last           <= 1'b0;
      tmp_user           <= 1'b0;
    end else begin
      state              <= state_next;
      pre_cnt            <= pre_cnt_next;
      len_cnt            <= len_cnt_next;
      s_ready            <= s_ready_next;
      int_ready          <= int_ready_early;
      busy               <= state_next != IDLE;
      error_bad_preamble <= bad_next;
      error_runt         <= runt_next;
      out_valid          <= out_valid_next;
      tmp_valid          <= tmp_valid_next;
      if (to_out) begin
        out_data <= int_data;
        out_last <= int_last;
        out_user <= int_user;
      end else if (tmp_to_out) begin
        out_data <= tmp_data;
        out_last <= tmp_last;
        out_user <= tmp_user;
      end
      if (to_tmp) begin
        tmp_data <= int_data;
        tmp_last <= int_last;
        tmp_user <= int_user;
      end
    end
  end

endmodule

// File: doc/axis_eth_preamble_strip.md
Name: axis_eth_preamble_strip

Overview:
Upstream neighbour of the FCS checker on the 8-bit receive path. Consumes a raw byte-wide AXI stream (one frame per tlast, starting with 0x55 preamble bytes and a 0xD5 SFD) and validates and removes preamble and SFD. Forwards destination MAC through FCS unchanged, flags runts in tuser, and discards frames with malformed preambles. Output feeds the FCS checker's s_axis_* directly.

Parameters:
MIN_PREAMBLE_LEN, 1, minimum count of 0x55 bytes required before SFD (0..7).
MAX_PREAMBLE_LEN, 7, maximum count of 0x55 bytes tolerated before SFD (>= MIN_PREAMBLE_LEN, <= 15).
MIN_FRAME_LENGTH, 64, minimum post-SFD byte count (including FCS); shorter frames are marked bad.

Ports:
clk  in  1  clock, all logic on rising edge.
rst  in  1  reset, asynchronous, active-high; clears all state registers.
s_axis_tdata  in  8  raw frame byte.
s_axis_tvalid  in  1  input valid.
s_axis_tready  out  1  input ready.
s_axis_tlast  in  1  last byte of raw frame.
s_axis_tuser  in  1  upstream error (PHY rx_er), sampled on the tlast beat.
m_axis_tdata  out  8  payload byte.
m_axis_tvalid  out  1  output valid.
m_axis_tready  in  1  output ready.
m_axis_tlast  out  1  last payload byte.
m_axis_tuser  out  1  bad frame, meaningful only with m_axis_tlast.
busy  out  1  high while state is not IDLE (registered from next state).
error_bad_preamble  out  1  one-cycle pulse per discarded frame.
error_runt  out  1  one-cycle pulse per forwarded runt frame.

Behaviour:
- Reset values: all outputs 0, state IDLE, counters 0, output and skid registers invalid.
- Output stage: 2-entry skid (output reg + temp reg), m_axis_tready_int_early registered. No combinational path from m_axis_tready to s_axis_tready. Latency: an accepted payload byte appears on m_axis one cycle later when the sink is ready.
- s_axis_tready: registered. In PAYLOAD it equals m_axis_tready_int_early. In IDLE, PREAMBLE and DROP it is 1, so the block never stalls on discarded bytes. It deasserts for one cycle after reset release.
- Preamble counter pre_cnt is 4 bits. Byte counter len_cnt is 16 bits and saturates at 0xFFFF.
- IDLE: on an accepted byte:
  - 0x55 -> pre_cnt=1, go to PREAMBLE.
  - 0xD5 with MIN_PREAMBLE_LEN==0 -> PAYLOAD.
  - Any other byte -> DROP.
- PREAMBLE: on an accepted byte:
  - 0x55 -> pre_cnt++. If pre_cnt would exceed MAX_PREAMBLE_LEN -> DROP.
  - 0xD5 with pre_cnt>=MIN_PREAMBLE_LEN -> PAYLOAD, len_cnt=0.
  - 0xD5 with pre_cnt<MIN_PREAMBLE_LEN -> DROP.
  - Any other byte -> DROP.
- Entry to DROP pulses error_bad_preamble once. DROP consumes bytes until tlast, then returns to IDLE.
- tlast in IDLE or PREAMBLE (frame ends before or on SFD): frame discarded, error_bad_preamble pulses, return to IDLE. Nothing is emitted.
- tlast in DROP: return to IDLE with no second pulse. If the DROP entry byte itself carries tlast, there is a single pulse and the next state is IDLE.
- PAYLOAD: each accepted byte is pushed to the output with len_cnt++. On tlast:
  - Emit the byte with m_axis_tlast=1.
  - m_axis_tuser = s_axis_tuser | (len_cnt+1 < MIN_FRAME_LENGTH).
  - If runt, pulse error_runt.
  - Go to IDLE.
- s_axis_tuser on non-last beats is ignored. Output tuser is 0 on non-last beats.
- A frame whose only byte after SFD is a tlast byte is forwarded as a 1-byte runt with tuser=1.
- Back-to-back frames: IDLE accepts a new frame's first byte on the cycle after the previous tlast is accepted. No idle gap is required.
- rst asserted mid-frame: state immediately returns to IDLE and the output and skid registers are cleared. A partial frame already emitted is not terminated by this block.

Test Plan:
- 7x0x55, 0xD5, 60 bytes 0x00..0x3B, 4-byte FCS, tlast; sink always ready -> 64 bytes out identical, tlast on the 64th, tuser=0, no error pulses.
- Same frame with 8x0x55 (MAX=7) -> no m_axis_tvalid for the whole frame, error_bad_preamble pulses exactly once, next good frame passes.
- 7x0x55, 0xD5, 20 bytes, tlast -> 20 bytes out, tuser=1 on last, error_runt pulses once.
- 0x55 0x55 0xAA, then 70 bytes, tlast, then a good 64-byte frame back-to-back -> first frame fully dropped with a single error pulse, second frame output intact.
- Good 100-byte frame with m_axis_tready toggling 1/0 every cycle and random s_axis_tvalid gaps -> byte order and count preserved, no duplication or loss, s_axis_tready never asserts with a full skid buffer.
- Assert rst during byte 30 of payload -> all outputs 0 immediately, busy=0; following good frame forwarded correctly.
